// File: rtl/lb_pkg.sv
// Shared encodings for the RX load-balancer core scheduler: policy modes,
// host register map and scheduler FSM states.
package lb_pkg;

  typedef enum logic [1:0] {
    LB_MODE_RR     = 2'd0,
    LB_MODE_LL     = 2'd1,
    LB_MODE_STICKY = 2'd2,
    LB_MODE_RSVD   = 2'd3
  } lb_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PICK = 2'd1,
    ST_POP  = 2'd2
  } lb_state_e;

  localparam int unsigned LB_HOST_CMD_W  = 29;
  localparam int unsigned LB_HOST_DATA_W = 32;
  localparam int unsigned LB_REG_ADDR_W  = 4;

  localparam logic [LB_REG_ADDR_W-1:0] LB_REG_MODE      = 4'd0;
  localparam logic [LB_REG_ADDR_W-1:0] LB_REG_RR_PTR    = 4'd1;
  localparam logic [LB_REG_ADDR_W-1:0] LB_REG_GRANT_CNT = 4'd2;
  localparam logic [LB_REG_ADDR_W-1:0] LB_REG_MAP_BASE  = 4'd4;

endpackage

// File: rtl/lb_core_pick.sv
// Combinational destination-core selection: rotating priority encoder for
// round-robin, max-reduction tree for least-loaded, direct lookup for sticky.
module lb_core_pick
  import lb_pkg::*;
#(
  parameter int unsigned CORE_COUNT    = 8,
  parameter int unsigned SLOT_WIDTH    = 6,
  parameter int unsigned CORE_ID_WIDTH = 3
) (
  input  lb_mode_e                        i_mode,
  input  logic [CORE_ID_WIDTH-1:0]        i_rr_ptr,
  input  logic [CORE_ID_WIDTH-1:0]        i_sticky_core,
  input  logic [CORE_COUNT-1:0]           i_elig,
  input  logic [CORE_COUNT*SLOT_WIDTH-1:0] i_slot_counts,
  output logic                            o_cand_valid_c,
  output logic [CORE_ID_WIDTH-1:0]        o_cand_core_c
);

  localparam int unsigned LVLS = CORE_ID_WIDTH;

  logic                     w_rr_vld;
  logic [CORE_ID_WIDTH-1:0] w_rr_core;
  logic [CORE_ID_WIDTH-1:0] w_rr_off;

  logic [SLOT_WIDTH-1:0]    w_t_cnt [LVLS+1][CORE_COUNT];
  logic [CORE_ID_WIDTH-1:0] w_t_idx [LVLS+1][CORE_COUNT];
  logic                     w_t_vld [LVLS+1][CORE_COUNT];
  logic                     w_left;

  // Rotating priority encoder: scan from the top so the lowest offset wins.
  always_comb begin
    w_rr_vld  = 1'b0;
    w_rr_core = i_rr_ptr;
    w_rr_off  = '0;
    for (int i = int'(CORE_COUNT) - 1; i >= 0; i--) begin
      w_rr_off = i_rr_ptr + CORE_ID_WIDTH'(i);
      if (i_elig[w_rr_off]) begin
        w_rr_vld  = 1'b1;
        w_rr_core = w_rr_off;
      end
    end
  end

  // Max tree; the left (lower-index) child wins ties.
  always_comb begin
    w_left = 1'b0;
    for (int l = 0; l <= int'(LVLS); l++) begin
      for (int j = 0; j < int'(CORE_COUNT); j++) begin
        w_t_cnt[l][j] = '0;
        w_t_idx[l][j] = '0;
        w_t_vld[l][j] = 1'b0;
      end
    end
    for (int j = 0; j < int'(CORE_COUNT); j++) begin
      w_t_cnt[0][j] = i_slot_counts[j*int'(SLOT_WIDTH) +: SLOT_WIDTH];
      w_t_idx[0][j] = CORE_ID_WIDTH'(j);
      w_t_vld[0][j] = i_elig[j];
    end
    for (int l = 0; l < int'(LVLS); l++) begin
      for (int j = 0; j < int'(CORE_COUNT / 2); j++) begin
        if (j < int'(CORE_COUNT >> (l + 1))) begin
          w_left = w_t_vld[l][2*j] &&
                   (!w_t_vld[l][2*j+1] || (w_t_cnt[l][2*j] >= w_t_cnt[l][2*j+1]));
          w_t_vld[l+1][j] = w_t_vld[l][2*j] | w_t_vld[l][2*j+1];
          w_t_cnt[l+1][j] = w_left ? w_t_cnt[l][2*j] : w_t_cnt[l][2*j+1];
          w_t_idx[l+1][j] = w_left ? w_t_idx[l][2*j] : w_t_idx[l][2*j+1];
        end
      end
    end
  end

  always_comb begin
    o_cand_valid_c = w_rr_vld;
    o_cand_core_c  = w_rr_core;
    case (i_mode)
      LB_MODE_LL: begin
        o_cand_valid_c = w_t_vld[LVLS][0];
        o_cand_core_c  = w_t_idx[LVLS][0];
      end
      LB_MODE_STICKY: begin
        o_cand_valid_c = i_elig[i_sticky_core];
        o_cand_core_c  = i_sticky_core;
      end
      default: begin
        o_cand_valid_c = w_rr_vld;
        o_cand_core_c  = w_rr_core;
      end
    endcase
  end

endmodule

// File: rtl/lb_sched_multi_policy.sv
// RX load-balancer core scheduler: arbitrates interface requests, picks a
// core by host-selected policy, pops its slot descriptor and returns it.
module lb_sched_multi_policy
  import lb_pkg::*;
#(
  parameter int unsigned IF_COUNT      = 3,
  parameter int unsigned CORE_COUNT    = 8,
  parameter int unsigned SLOT_COUNT    = 32,
  parameter int unsigned SLOT_WIDTH    = $clog2(SLOT_COUNT + 1),
  parameter int unsigned CORE_ID_WIDTH = $clog2(CORE_COUNT),
  parameter int unsigned TAG_WIDTH     = (SLOT_WIDTH > 5) ? SLOT_WIDTH : 5,
  parameter int unsigned ID_TAG_WIDTH  = CORE_ID_WIDTH + TAG_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [IF_COUNT-1:0]              req_valid,
  output logic [IF_COUNT-1:0]              req_ready,
  output logic [ID_TAG_WIDTH-1:0]          grant_desc,
  input  logic [CORE_COUNT-1:0]            enabled_cores,
  input  logic [CORE_COUNT*SLOT_WIDTH-1:0] slot_counts,
  input  logic [CORE_COUNT-1:0]            slot_valids,
  input  logic [CORE_COUNT-1:0]            slot_busys,
  output logic [CORE_ID_WIDTH-1:0]         selected_core,
  output logic                             desc_pop,
  input  logic [ID_TAG_WIDTH-1:0]          desc_data,
  input  logic [LB_HOST_CMD_W-1:0]         host_cmd,
  input  logic [LB_HOST_DATA_W-1:0]        host_cmd_wr_data,
  input  logic                             host_cmd_wr_en,
  output logic [LB_HOST_DATA_W-1:0]        host_cmd_rd_data
);

  localparam int unsigned IF_ID_WIDTH = (IF_COUNT > 1) ? $clog2(IF_COUNT) : 1;

  lb_state_e                 r_state;
  lb_state_e                 w_state_nxt;
  lb_mode_e                  r_mode;
  lb_mode_e                  r_mode_act;
  logic [IF_ID_WIDTH-1:0]    r_req_if;
  logic [IF_ID_WIDTH-1:0]    r_if_ptr;
  logic [CORE_ID_WIDTH-1:0]  r_rr_ptr;
  logic [31:0]               r_grant_cnt;
  logic [CORE_ID_WIDTH-1:0]  r_map [IF_COUNT];
  logic [CORE_ID_WIDTH-1:0]  r_sel_core;
  logic                      r_desc_pop;
  logic [IF_COUNT-1:0]       r_req_ready;
  logic [ID_TAG_WIDTH-1:0]   r_grant_desc;
  logic [LB_HOST_DATA_W-1:0] r_rd_data;

  logic [CORE_COUNT-1:0]     w_elig;
  logic                      w_req_any;
  logic [IF_ID_WIDTH-1:0]    w_req_sel;
  logic [IF_ID_WIDTH-1:0]    w_req_idx;
  logic                      w_cand_valid_c;
  logic [CORE_ID_WIDTH-1:0]  w_cand_core_c;
  logic [LB_REG_ADDR_W-1:0]  w_addr;
  logic [LB_HOST_DATA_W-1:0] w_rd_data;
  logic                      w_unused_host;

  assign w_elig        = enabled_cores & slot_valids & ~slot_busys;
  assign w_addr        = host_cmd[LB_REG_ADDR_W-1:0];
  assign w_unused_host = ^{host_cmd[LB_HOST_CMD_W-1:LB_REG_ADDR_W],
                           host_cmd_wr_data[LB_HOST_DATA_W-1:CORE_ID_WIDTH]};

  assign req_ready        = r_req_ready;
  assign grant_desc       = r_grant_desc;
  assign selected_core    = r_sel_core;
  assign desc_pop         = r_desc_pop;
  assign host_cmd_rd_data = r_rd_data;

  // Requester: first asserted req_valid at or after if_ptr, wrapping at IF_COUNT.
  always_comb begin
    w_req_any = 1'b0;
    w_req_sel = r_if_ptr;
    w_req_idx = '0;
    for (int i = int'(IF_COUNT) - 1; i >= 0; i--) begin
      if (int'(r_if_ptr) + i >= int'(IF_COUNT))
        w_req_idx = IF_ID_WIDTH'(int'(r_if_ptr) + i - int'(IF_COUNT));
      else
        w_req_idx = IF_ID_WIDTH'(int'(r_if_ptr) + i);
      if (req_valid[w_req_idx]) begin
        w_req_any = 1'b1;
        w_req_sel = w_req_idx;
      end
    end
  end

  lb_core_pick #(
    .CORE_COUNT    (CORE_COUNT),
    .SLOT_WIDTH    (SLOT_WIDTH),
    .CORE_ID_WIDTH (CORE_ID_WIDTH)
  ) u_core_pick (
    .i_mode         (r_mode_act),
    .i_rr_ptr       (r_rr_ptr),
    .i_sticky_core  (r_map[r_req_if]),
    .i_elig         (w_elig),
    .i_slot_counts  (slot_counts),
    .o_cand_valid_c (w_cand_valid_c),
    .o_cand_core_c  (w_cand_core_c)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_req_any) w_state_nxt = ST_PICK;
      ST_PICK: if (w_cand_valid_c) w_state_nxt = ST_POP;
      ST_POP:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Transaction datapath: mode shadow, grant capture and pointer updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode_act   <= LB_MODE_RR;
      r_req_if     <= '0;
      r_if_ptr     <= '0;
      r_rr_ptr     <= '0;
      r_sel_core   <= '0;
      r_desc_pop   <= 1'b0;
      r_req_ready  <= '0;
      r_grant_desc <= '0;
    end else begin
      r_desc_pop  <= 1'b0;
      r_req_ready <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_req_any) begin
            r_req_if   <= w_req_sel;
            r_mode_act <= r_mode;
          end
        end
        ST_PICK: begin
          r_sel_core <= w_cand_core_c;
          r_desc_pop <= w_cand_valid_c;
        end
        ST_POP: begin
          r_grant_desc <= desc_data;
          r_req_ready  <= IF_COUNT'(1) << r_req_if;
          r_if_ptr     <= (r_req_if == IF_ID_WIDTH'(IF_COUNT - 1)) ? '0 : r_req_if + 1'b1;
          if ((r_mode_act != LB_MODE_LL) && (r_mode_act != LB_MODE_STICKY))
            r_rr_ptr <= r_sel_core + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Host-writable registers; a grant_cnt write-clear wins over a same-cycle grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode      <= LB_MODE_RR;
      r_grant_cnt <= '0;
      r_rd_data   <= '0;
      for (int i = 0; i < int'(IF_COUNT); i++)
        r_map[i] <= CORE_ID_WIDTH'(i % int'(CORE_COUNT));
    end else begin
      if (host_cmd_wr_en && (w_addr == LB_REG_MODE))
        r_mode <= lb_mode_e'(host_cmd_wr_data[1:0]);
      for (int i = 0; i < int'(IF_COUNT); i++) begin
        if (host_cmd_wr_en && (w_addr == LB_REG_MAP_BASE + LB_REG_ADDR_W'(i)))
          r_map[i] <= host_cmd_wr_data[CORE_ID_WIDTH-1:0];
      end
      if (host_cmd_wr_en && (w_addr == LB_REG_GRANT_CNT))
        r_grant_cnt <= '0;
      else if (r_state == ST_POP)
        r_grant_cnt <= r_grant_cnt + 32'd1;
      r_rd_data <= w_rd_data;
    end
  end

  always_comb begin
    w_rd_data = '0;
    case (w_addr)
      LB_REG_MODE:      w_rd_data = LB_HOST_DATA_W'(r_mode);
      LB_REG_RR_PTR:    w_rd_data = LB_HOST_DATA_W'(r_rr_ptr);
      LB_REG_GRANT_CNT: w_rd_data = r_grant_cnt;
      default: begin
        for (int i = 0; i < int'(IF_COUNT); i++) begin
          if (w_addr == LB_REG_MAP_BASE + LB_REG_ADDR_W'(i))
            w_rd_data = LB_HOST_DATA_W'(r_map[i]);
        end
      end
    endcase
  end

endmodule
